// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among NUM_REQ
// byte-stream requesters; all outputs are registered.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned BUSY_TIMEOUT = 16,
  parameter int unsigned MAX_PKT      = 255
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic                   tx_start_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_ready_i
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_PKT + 1);
  localparam int unsigned TMR_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PKT);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   owner, owner_d, rr_ptr, rr_ptr_d, pick, next_ptr;
  logic [CNT_W-1:0]   byte_cnt, byte_cnt_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic               last_q, last_d, pick_vld;
  logic               own_valid, own_last;
  logic [7:0]         own_data, data_d;
  logic [NUM_REQ-1:0] grant_d, ready_d;
  logic               start_d;

  // Cyclic search from rr_ptr: first pass covers indices >= rr_ptr, second wraps.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && req_valid_i[i] && (IDX_W'(i) >= rr_ptr)) begin
        pick     = IDX_W'(i);
        pick_vld = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && req_valid_i[i]) begin
        pick     = IDX_W'(i);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        own_valid = req_valid_i[i];
        own_last  = req_last_i[i];
        own_data  = req_data_i[8*i +: 8];
      end
    end
  end

  assign next_ptr = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      byte_cnt    <= '0;
      last_q      <= 1'b0;
      timer       <= '0;
      grant_o     <= '0;
      req_ready_o <= '0;
      tx_start_o  <= 1'b0;
      tx_data_o   <= '0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_d;
      owner       <= owner_d;
      rr_ptr      <= rr_ptr_d;
      byte_cnt    <= byte_cnt_d;
      last_q      <= last_d;
      timer       <= timer_d;
      grant_o     <= grant_d;
      req_ready_o <= ready_d;
      tx_start_o  <= start_d;
      tx_data_o   <= data_d;
      busy_o      <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (tx_ready_i && pick_vld) state_d = SEND;
      SEND: begin
        if (own_valid)             state_d = WAIT_BUSY;
        else if (timer == TMO_LAST) state_d = IDLE;
      end
      WAIT_BUSY: if (!tx_ready_i || (timer == TMO_LAST)) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_ready_i)
          state_d = (last_q || (byte_cnt == MAX_CNT)) ? IDLE : SEND;
      end
      default:   state_d = IDLE;
    endcase
  end

  // The single timer serves both the stalled-requester and missing-busy timeouts.
  always_comb begin
    owner_d    = owner;
    rr_ptr_d   = rr_ptr;
    byte_cnt_d = byte_cnt;
    last_d     = last_q;
    timer_d    = timer;
    grant_d    = grant_o;
    ready_d    = '0;
    start_d    = 1'b0;
    data_d     = tx_data_o;
    case (state)
      IDLE: begin
        timer_d = '0;
        if (tx_ready_i && pick_vld) begin
          owner_d    = pick;
          grant_d    = NUM_REQ'(1) << pick;
          byte_cnt_d = '0;
        end
      end
      SEND: begin
        if (own_valid) begin
          data_d     = own_data;
          start_d    = 1'b1;
          ready_d    = grant_o;
          byte_cnt_d = byte_cnt + CNT_W'(1);
          last_d     = own_last;
          timer_d    = '0;
        end else if (timer == TMO_LAST) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          timer_d  = '0;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      WAIT_BUSY: begin
        if (!tx_ready_i || (timer == TMO_LAST)) timer_d = '0;
        else                                    timer_d = timer + TMR_W'(1);
      end
      WAIT_DONE: begin
        timer_d = '0;
        if (tx_ready_i && (last_q || (byte_cnt == MAX_CNT))) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized packet traffic checked against a queue-based arbitration model.
module tb_uart_tx_arbiter;

  localparam int NR   = 3;
  localparam int MAXP = 255;

  logic            clk, rstn;
  logic [NR-1:0]   req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [8*NR-1:0] req_data_i;
  logic            busy_o, tx_start_o, tx_ready_i;
  logic [7:0]      tx_data_o;

  typedef struct { logic [7:0] data; bit last; int stall; } item_t;
  typedef struct { int req; logic [7:0] data; } ev_t;
  typedef struct { logic [2:0] valid; logic [23:0] data; logic [2:0] exp_grant; logic [7:0] exp_data; } vec_t;

  item_t rq[NR][$];
  int    stall_q[NR];
  ev_t   log_q[$];
  int    rdy_cnt[NR];
  int    start_cnt = 0;
  int    tx_mode = 0, tx_len = 2, tx_cnt = 0;
  int    checks = 0, errors = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(16), .MAX_PKT(MAXP)) dut (
    .clk(clk), .rstn(rstn), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .grant_o(grant_o),
    .busy_o(busy_o), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
    .tx_ready_i(tx_ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_log(input string name, input int k, input int req, input logic [7:0] d);
    logic [31:0] act;
    act = (k < log_q.size()) ? 32'(log_q[k].req * 256 + int'(log_q[k].data)) : 32'hFFFF_FFFF;
    check(name, act, 32'(req * 256 + int'(d)));
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit l, input int s);
    item_t it;
    it.data = d; it.last = l; it.stall = s;
    if (rq[r].size() == 0) stall_q[r] = s;
    rq[r].push_back(it);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NR; i++) begin
      rq[i].delete();
      stall_q[i] = 0;
    end
  endtask

  function automatic bit all_empty();
    return (rq[0].size() == 0) && (rq[1].size() == 0) && (rq[2].size() == 0);
  endfunction

  function automatic int idx_of(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic wait_idle(input int limit, input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < limit && !done; n++) begin
      @(posedge clk); #1;
      if (!busy_o && all_empty()) done = 1'b1;
    end
    check({name, "_idle"}, done, 1);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    clear_queues();
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_start", tx_start_o, 0);
    check("rst_data", tx_data_o, 0);
    check("rst_ready", req_ready_o, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    log_q.delete();
    start_cnt = 0;
    for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
  endtask

  // Requester model: each queue head is presented while its stall count is zero.
  initial begin
    req_valid_i = '0; req_data_i = '0; req_last_i = '0;
    for (int i = 0; i < NR; i++) stall_q[i] = 0;
    forever begin
      @(posedge clk); #2;
      for (int i = 0; i < NR; i++) begin
        if (req_ready_o[i] && rq[i].size() > 0) begin
          void'(rq[i].pop_front());
          if (rq[i].size() > 0) stall_q[i] = rq[i][0].stall;
        end else if (stall_q[i] > 0) begin
          stall_q[i]--;
        end
        if (rq[i].size() > 0 && stall_q[i] == 0) begin
          req_valid_i[i]        = 1'b1;
          req_data_i[8*i +: 8]  = rq[i][0].data;
          req_last_i[i]         = rq[i][0].last;
        end else begin
          req_valid_i[i] = 1'b0;
          req_last_i[i]  = 1'b0;
        end
      end
    end
  end

  // Transmitter model: mode 0 drops ready for tx_len cycles, 1 random 0..6, 2 stuck high.
  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!rstn || tx_mode == 2) begin
        tx_ready_i = 1'b1;
        tx_cnt     = 0;
      end else if (tx_start_o) begin
        tx_cnt     = (tx_mode == 1) ? int'($urandom_range(0, 6)) : tx_len;
        tx_ready_i = (tx_cnt == 0);
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        tx_ready_i = (tx_cnt == 0);
      end
    end
  end

  initial begin
    bit ok;
    forever begin
      @(posedge clk); #1;
      if (rstn) begin
        ok = $onehot0(grant_o) && ((req_ready_o & ~grant_o) == '0) &&
             (tx_start_o == (|req_ready_o)) && (busy_o || grant_o == '0);
        check("invariants", ok, 1);
        if (tx_start_o) begin
          ev_t e;
          e.req  = idx_of(req_ready_o);
          e.data = tx_data_o;
          log_q.push_back(e);
          start_cnt++;
        end
        for (int i = 0; i < NR; i++) if (req_ready_o[i]) rdy_cnt[i]++;
      end
    end
  end

  initial begin
    vec_t  tbl[10];
    item_t mq[NR][$];
    ev_t   exp_q[$];
    ev_t   e;
    item_t it;
    bit    got, fin;
    int    n, own, ptr, len;

    tbl[0] = '{3'b111, 24'h121110, 3'b001, 8'h10};
    tbl[1] = '{3'b111, 24'h222120, 3'b010, 8'h21};
    tbl[2] = '{3'b111, 24'h323130, 3'b100, 8'h32};
    tbl[3] = '{3'b111, 24'h424140, 3'b001, 8'h40};
    tbl[4] = '{3'b001, 24'h525150, 3'b001, 8'h50};
    tbl[5] = '{3'b101, 24'h626160, 3'b100, 8'h62};
    tbl[6] = '{3'b110, 24'h727170, 3'b010, 8'h71};
    tbl[7] = '{3'b011, 24'h828180, 3'b001, 8'h80};
    tbl[8] = '{3'b100, 24'h929190, 3'b100, 8'h92};
    tbl[9] = '{3'b010, 24'hA2A1A0, 3'b010, 8'hA1};

    rstn = 1'b0;
    apply_reset();

    // Three-byte packet, slow transmitter, exact grant/start latency
    tx_mode = 0; tx_len = 10;
    push_byte(0, 8'h41, 0, 0); push_byte(0, 8'h42, 0, 0); push_byte(0, 8'h43, 1, 0);
    @(posedge clk); #1;
    check("t1_grant_lat", grant_o, 3'b001);
    check("t1_no_early_start", tx_start_o, 0);
    @(posedge clk); #1;
    check("t1_start_lat", tx_start_o, 1);
    check("t1_first_data", tx_data_o, 8'h41);
    check("t1_first_ready", req_ready_o, 3'b001);
    wait_idle(200, "t1");
    check("t1_starts", start_cnt, 3);
    check("t1_ready_pulses", rdy_cnt[0], 3);
    check_log("t1_byte0", 0, 0, 8'h41);
    check_log("t1_byte1", 1, 0, 8'h42);
    check_log("t1_byte2", 2, 0, 8'h43);
    check("t1_grant_free", grant_o, 0);

    // Vector table of single-byte arbitration rounds
    apply_reset();
    tx_len = 2;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NR; i++)
        if (tbl[r].valid[i]) push_byte(i, tbl[r].data[8*i +: 8], 1, 0);
      got = 1'b0;
      for (int k = 0; k < 6 && !got; k++) begin
        @(posedge clk); #1;
        if (grant_o != '0) got = 1'b1;
      end
      check($sformatf("tbl%0d_grant", r), grant_o, tbl[r].exp_grant);
      got = 1'b0;
      for (int k = 0; k < 6 && !got; k++) begin
        @(posedge clk); #1;
        if (tx_start_o) got = 1'b1;
      end
      check($sformatf("tbl%0d_start", r), got, 1);
      check($sformatf("tbl%0d_data", r), tx_data_o, tbl[r].exp_data);
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(posedge clk); #1;
        if (!busy_o) got = 1'b1;
      end
      check($sformatf("tbl%0d_release", r), got, 1);
      clear_queues();
    end

    // Req1 holds the transmitter through a mid-packet stall while req0 waits
    log_q.delete();
    tx_len = 3;
    push_byte(1, 8'h31, 0, 0); push_byte(1, 8'h32, 0, 0);
    push_byte(1, 8'h33, 0, 2); push_byte(1, 8'h34, 1, 0);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(posedge clk); #1;
      if (grant_o != '0) got = 1'b1;
    end
    check("t3_grant_req1", grant_o, 3'b010);
    push_byte(0, 8'h35, 1, 0);
    wait_idle(300, "t3");
    check("t3_count", log_q.size(), 5);
    for (int k = 0; k < 4; k++) check_log($sformatf("t3_req1_b%0d", k), k, 1, 8'(8'h31 + k));
    check_log("t3_req0_after", 4, 0, 8'h35);

    // Transmitter never drops ready: WAIT_BUSY must time out
    log_q.delete();
    tx_mode = 2;
    push_byte(2, 8'h5C, 1, 0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk); #1;
      if (tx_start_o) got = 1'b1;
    end
    check("t4_start", got, 1);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!busy_o) got = 1'b1;
    end
    check("t4_busy_cycles", n, 17);
    check_log("t4_byte", 0, 2, 8'h5C);
    tx_mode = 0;

    // 300-byte stream with no last flag: forced release at MAX_PKT
    log_q.delete();
    tx_len = 1;
    for (int k = 0; k < 300; k++) push_byte(2, 8'(k), 0, 0);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(posedge clk); #1;
      if (grant_o != '0) got = 1'b1;
    end
    check("t5_grant_req2", grant_o, 3'b100);
    push_byte(0, 8'hE0, 1, 0);
    wait_idle(5000, "t5");
    check("t5_count", log_q.size(), 301);
    for (int k = 0; k < 301; k++) begin
      if (k < MAXP)       check_log("t5_first_chunk", k, 2, 8'(k));
      else if (k == MAXP) check_log("t5_req0_between", k, 0, 8'hE0);
      else                check_log("t5_second_chunk", k, 2, 8'(k - 1));
    end
    check("t5_grant_free", grant_o, 0);

    // Asynchronous reset while waiting for the transmitter to finish
    tx_len = 2;
    push_byte(0, 8'h60, 1, 0);
    wait_idle(50, "t6_pre");
    tx_len = 10;
    push_byte(1, 8'h5A, 1, 0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk); #1;
      if (tx_start_o) got = 1'b1;
    end
    check("t6_start", got, 1);
    repeat (4) @(posedge clk);
    #3;
    check("t6_busy_before", busy_o, 1);
    rstn = 1'b0;
    #1;
    check("t6_async_grant", grant_o, 0);
    check("t6_async_busy", busy_o, 0);
    check("t6_async_data", tx_data_o, 0);
    check("t6_async_start", tx_start_o, 0);
    clear_queues();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    log_q.delete();
    tx_len = 2;
    push_byte(2, 8'h77, 1, 0);
    push_byte(0, 8'h66, 1, 0);
    @(posedge clk); #1;
    check("t6_fresh_grant", grant_o, 3'b001);
    wait_idle(100, "t6");
    check_log("t6_first", 0, 0, 8'h66);
    check_log("t6_second", 1, 2, 8'h77);

    // Random packets, all queued up front, against the round-robin model
    apply_reset();
    tx_mode = 1;
    for (int p = 0; p < 30; p++) begin
      own = $urandom_range(0, NR - 1);
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        it.data  = 8'($urandom);
        it.last  = (b == len - 1);
        it.stall = (b == 0) ? 0 : int'($urandom_range(0, 3));
        push_byte(own, it.data, it.last, it.stall);
        mq[own].push_back(it);
      end
    end
    ptr = 0;
    while (mq[0].size() + mq[1].size() + mq[2].size() > 0) begin
      own = -1;
      for (int k = 0; k < NR; k++)
        if (own < 0 && mq[(ptr + k) % NR].size() > 0) own = (ptr + k) % NR;
      n = 0;
      fin = 1'b0;
      while (!fin) begin
        it = mq[own].pop_front();
        e.req = own; e.data = it.data;
        exp_q.push_back(e);
        n++;
        fin = it.last || (n == MAXP) || (mq[own].size() == 0);
      end
      ptr = (own + 1) % NR;
    end
    wait_idle(10000, "rand");
    check("rand_count", log_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      check_log($sformatf("rand_ev%0d", k), k, exp_q[k].req, exp_q[k].data);
    check("rand_grant_free", grant_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
